// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   state_e   : responder FSM states (S_IDLE, S_WAIT, S_RESP).
//   MODE_WORD / MODE_BYTE : req_mode encodings.
//   lane_be() : byte-lane enable decode from access mode and byte offset.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic MODE_WORD = 1'b0;
    localparam logic MODE_BYTE = 1'b1;

    // Word accesses enable all four lanes; byte accesses enable only the addressed lane.
    function automatic logic [3:0] lane_be(input logic mode, input logic [1:0] lane);
        if (mode == MODE_BYTE) begin
            return 4'b0001 << lane;
        end
        return 4'b1111;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request/response bundle between the core LSU and the responder.
//   req_valid/req_ready : request handshake (master -> slave).
//   req_write, req_mode, req_addr, req_wdata : request payload.
//   rsp_valid/rsp_ready : response handshake (slave -> master).
//   rsp_rdata, rsp_err  : response payload.
//   modports: master (core side), slave (responder side).
interface dmem_responder_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_mode;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_mode, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_mode, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: byte-addressable data storage organised as 4 byte lanes per word.
//   clk_i   : clock, rising edge.
//   we_i    : write strobe.
//   be_i    : per-lane byte enable (lane 0 = bits [7:0]).
//   waddr_i : word index (shared by read and write).
//   wdata_i : write data, lane i taken from bits [8i+7:8i].
//   rdata_o : combinational read of the whole word at waddr_i.
// Contents are not reset.
module dmem_array #(
    parameter int unsigned WORD_ADDR_BITS = 15
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [WORD_ADDR_BITS-1:0] waddr_i,
    input  logic [31:0]               wdata_i,
    output logic [31:0]               rdata_o
);
    localparam int unsigned DEPTH = 2 ** WORD_ADDR_BITS;

    logic [3:0][7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][i] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[waddr_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core load/store port.
//   clk : clock, rising edge.
//   rst : asynchronous reset, active-high.
//   bus : dmem_responder_if.slave - request/response handshake and payload.
// Accepts one request in IDLE, waits LATENCY cycles, performs a word or byte
// access on the internal array (little-endian), then holds the response
// until rsp_ready. Address bits above MEM_ADDR_BITS are ignored (wrap).
// Build option: define DMEM_MISALIGN_ERR_EN to flag word accesses with a
// non-zero byte offset (no write, rdata 0, rsp_err 1); otherwise the offset
// is dropped and rsp_err stays 0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned MEM_ADDR_BITS = 17,
    parameter int unsigned LATENCY       = 2
) (
    input logic              clk,
    input logic              rst,
    dmem_responder_if.slave  bus
);
    localparam int unsigned WORD_ADDR_BITS = MEM_ADDR_BITS - 2;
    localparam logic [3:0]  CNT_LOAD       = 4'(LATENCY - 1);

    state_e                   state_q;
    logic [3:0]               cnt_q;
    logic                     wr_q;
    logic                     mode_q;
    logic [MEM_ADDR_BITS-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     err_q;
    logic                     req_ready_q;
    logic                     rsp_valid_q;

    logic                     access;
    logic                     misalign;
    logic                     arr_we;
    logic [DATA_WIDTH-1:0]    arr_wdata;
    logic [DATA_WIDTH-1:0]    arr_rdata;
    logic [DATA_WIDTH-1:0]    rdata_d;
    logic                     unused_addr_hi;

    assign unused_addr_hi = &{1'b0, bus.req_addr[ADDR_WIDTH-1:MEM_ADDR_BITS]};

    // The access happens on the final WAIT edge; the write commits only there.
    assign access = (state_q == S_WAIT) && (cnt_q == '0);

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign = (mode_q == MODE_WORD) && (addr_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign arr_we    = access && wr_q && !misalign;
    // Byte stores replicate the low byte; the lane enable picks the target.
    assign arr_wdata = (mode_q == MODE_BYTE) ? {4{wdata_q[7:0]}} : wdata_q;

    dmem_array #(
        .WORD_ADDR_BITS(WORD_ADDR_BITS)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .be_i    (lane_be(mode_q, addr_q[1:0])),
        .waddr_i (addr_q[MEM_ADDR_BITS-1:2]),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        rdata_d = '0;
        if (!wr_q && !misalign) begin
            if (mode_q == MODE_BYTE) begin
                rdata_d = {24'b0, arr_rdata[{addr_q[1:0], 3'b000} +: 8]};
            end else begin
                rdata_d = arr_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            mode_q      <= MODE_WORD;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        wr_q        <= bus.req_write;
                        mode_q      <= bus.req_mode;
                        addr_q      <= bus.req_addr[MEM_ADDR_BITS-1:0];
                        wdata_q     <= bus.req_wdata;
                        cnt_q       <= CNT_LOAD;
                        req_ready_q <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q     <= rdata_d;
                        err_q       <= misalign;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
// (LATENCY=2, MEM_ADDR_BITS=17). Honors DMEM_MISALIGN_ERR_EN for the
// misaligned word-load check.
module tb_dmem_responder;
    localparam int unsigned LAT = 2;
    localparam int unsigned MAB = 17;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dmem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    dmem_responder #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .MEM_ADDR_BITS(MAB),
        .LATENCY      (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold = cycles rsp_ready is kept low once rsp_valid is seen.
    task automatic xact(input logic w, input logic m, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er);
        int n;
        int lat;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_mode  = m;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("acc_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        // Scramble the request bus after acceptance; it must not matter.
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_mode  = ~m;
        bus.req_addr  = 32'h0000_0040;
        bus.req_wdata = $urandom;
        chk("wait_ready", {31'b0, bus.req_ready}, 32'd0);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, LAT);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("bp_rdata", bus.rsp_rdata, rd);
            chk("bp_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", {31'b0, bus.rsp_valid}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_mode  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);

        // Word store then load.
        xact(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 0, rd, er);
        chk("st_rdata", rd, 32'd0);
        chk("st_err", {31'b0, er}, 32'd0);
        xact(1'b0, 1'b0, 32'h100, 32'h0, 0, rd, er);
        chk("ld_word", rd, 32'hDEAD_BEEF);

        // Byte store into lane 1 (upper wdata bits must be ignored).
        xact(1'b1, 1'b1, 32'h101, 32'hFFFF_FFAA, 0, rd, er);
        xact(1'b0, 1'b0, 32'h100, 32'h0, 0, rd, er);
        chk("ld_after_bst", rd, 32'hDEAD_AAEF);
        xact(1'b0, 1'b1, 32'h103, 32'h0, 0, rd, er);
        chk("ld_byte3", rd, 32'h0000_00DE);

        // Backpressure for 5 cycles in RESP.
        xact(1'b0, 1'b0, 32'h100, 32'h0, 5, rd, er);
        chk("bp_word", rd, 32'hDEAD_AAEF);

        // Address wrap modulo 2**MAB.
        xact(1'b1, 1'b0, (32'd1 << MAB) + 32'h20, 32'h1234_5678, 0, rd, er);
        xact(1'b0, 1'b0, 32'h20, 32'h0, 0, rd, er);
        chk("ld_wrap", rd, 32'h1234_5678);

        // Reset during WAIT of a store: store must not commit.
        xact(1'b1, 1'b0, 32'h40, 32'h0, 0, rd, er);
        xact(1'b0, 1'b0, 32'h20, 32'h0, 0, rd, er);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_mode  = 1'b0;
        bus.req_addr  = 32'h40;
        bus.req_wdata = 32'h1111_1111;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("mid_rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xact(1'b0, 1'b0, 32'h40, 32'h0, 0, rd, er);
        chk("ld_after_rst", rd, 32'h0);

        // Misaligned word load, and byte load at the same offset.
        xact(1'b0, 1'b0, 32'h102, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
        chk("mis_rdata", rd, 32'h0);
        chk("mis_err", {31'b0, er}, 32'd1);
`else
        chk("mis_rdata", rd, 32'hDEAD_AAEF);
        chk("mis_err", {31'b0, er}, 32'd0);
`endif
        xact(1'b0, 1'b1, 32'h102, 32'h0, 0, rd, er);
        chk("byte_off2", rd, 32'h0000_00AD);
        chk("byte_off2_err", {31'b0, er}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
